// File: rtl/thor2024_pma_checker.sv
// Physical memory attribute checker: a small table of address regions with
// per-region attributes, programmed over a simple register bus, plus a
// two-stage lookup pipeline that classifies an access against the table.
module thor2024_pma_checker #(
  parameter int unsigned NRGN       = 8,
  parameter int unsigned ABITS      = 32,
  parameter logic [31:0] BOOT_LIMIT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  // register bus
  input  logic             cs,
  input  logic             cyc,
  input  logic             stb,
  input  logic             we,
  input  logic [11:0]      adr,
  input  logic [63:0]      dat,
  output logic             ack,
  output logic [63:0]      dato,
  // lookup request
  input  logic             lk_v,
  input  logic [ABITS-1:0] lk_adr,
  input  logic [2:0]       lk_acc,
  // lookup result
  output logic             lk_ov,
  output logic [3:0]       lk_rgn,
  output logic [15:0]      lk_attr,
  output logic             lk_fault,
  output logic             lk_nomatch
);

  localparam logic [ABITS-1:0] BootLimit = ABITS'(BOOT_LIMIT);
  localparam int unsigned      BootRgn   = NRGN - 1;
  localparam logic [15:0]      BootAttr  = 16'h014D;

  // Region table
  logic [ABITS-1:0] base_q  [NRGN];
  logic [ABITS-1:0] limit_q [NRGN];
  logic [15:0]      attr_q  [NRGN];
  logic [NRGN-1:0]  en_q, lock_q, sticky_q;

  // Bus state
  logic        ack_q;
  logic [63:0] dato_q;
  logic        bus_req, bus_accept;
  logic [4:0]  rsel;
  logic [1:0]  fld;
  logic [63:0] rd_word;

  // Lookup pipeline
  logic            s1_v_q;
  logic [NRGN-1:0] s1_hit_q, hit_d;
  logic [2:0]      s1_acc_q;
  logic            sel_found;
  logic [3:0]      sel_idx;
  logic [15:0]     sel_attr;
  logic            fault_d;
  logic            lk_ov_q, lk_fault_q, lk_nomatch_q;
  logic [3:0]      lk_rgn_q;
  logic [15:0]     lk_attr_q;

  // Address bits outside the decoded map and data bits wider than a field.
  logic unused_bits;
  assign unused_bits = ^{dat[63:ABITS], adr[11:10], adr[2:0]};

  assign bus_req    = cs & cyc & stb;
  assign bus_accept = bus_req & ~ack_q;
  assign rsel       = adr[9:5];
  assign fld        = adr[4:3];

  // Read mux; unimplemented regions fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NRGN); i++) begin
      if (rsel == 5'(i)) begin
        unique case (fld)
          2'd0:    rd_word = 64'(base_q[i]);
          2'd1:    rd_word = 64'(limit_q[i]);
          2'd2:    rd_word = 64'(attr_q[i]);
          default: rd_word = {61'b0, sticky_q[i], lock_q[i], en_q[i]};
        endcase
      end
    end
  end

  // Bus handshake: ack held until the cycle after the request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      dato_q <= '0;
    end else if (bus_accept) begin
      ack_q  <= 1'b1;
      dato_q <= we ? 64'd0 : rd_word;
    end else if (ack_q && !bus_req) begin
      ack_q  <= 1'b0;
      dato_q <= '0;
    end
  end

  // Table writes; lock guards the address/attr fields, sticky guards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NRGN); i++) begin
        base_q[i]   <= '0;
        limit_q[i]  <= (i == int'(BootRgn)) ? BootLimit : '0;
        attr_q[i]   <= (i == int'(BootRgn)) ? BootAttr : '0;
        en_q[i]     <= (i == int'(BootRgn));
        lock_q[i]   <= (i == int'(BootRgn));
        sticky_q[i] <= 1'b0;
      end
    end else if (bus_accept && we) begin
      for (int i = 0; i < int'(NRGN); i++) begin
        if (rsel == 5'(i) && !sticky_q[i]) begin
          unique case (fld)
            2'd0: if (!lock_q[i]) base_q[i] <= dat[ABITS-1:0];
            2'd1: if (!lock_q[i]) limit_q[i] <= dat[ABITS-1:0];
            2'd2: if (!lock_q[i]) attr_q[i] <= dat[15:0];
            default: begin
              en_q[i]     <= dat[0];
              lock_q[i]   <= dat[1];
              sticky_q[i] <= dat[2];
            end
          endcase
        end
      end
    end
  end

  // Stage 1 hit compare against the current (pre-write) table.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(NRGN); i++) begin
      hit_d[i] = en_q[i] && (base_q[i] <= lk_adr) && (lk_adr <= limit_q[i]);
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_hit_q <= '0;
      s1_acc_q <= '0;
    end else begin
      s1_v_q   <= lk_v;
      s1_hit_q <= hit_d;
      s1_acc_q <= lk_acc;
    end
  end

  // Stage 2 priority select: scanning downward leaves the lowest hit selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_attr  = '0;
    for (int i = int'(NRGN) - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
        sel_attr  = attr_q[i];
      end
    end
    fault_d = sel_found ? ((|(s1_acc_q & ~sel_attr[2:0])) | (sel_attr[15:8] == 8'hFF))
                        : 1'b1;
  end

  // Stage 2 result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_ov_q      <= 1'b0;
      lk_rgn_q     <= '0;
      lk_attr_q    <= '0;
      lk_fault_q   <= 1'b0;
      lk_nomatch_q <= 1'b0;
    end else begin
      lk_ov_q <= s1_v_q;
      if (s1_v_q) begin
        lk_rgn_q     <= sel_idx;
        lk_attr_q    <= sel_attr;
        lk_fault_q   <= fault_d;
        lk_nomatch_q <= ~sel_found;
      end
    end
  end

  assign ack        = ack_q;
  assign dato       = dato_q;
  assign lk_ov      = lk_ov_q;
  assign lk_rgn     = lk_rgn_q;
  assign lk_attr    = lk_attr_q;
  assign lk_fault   = lk_fault_q;
  assign lk_nomatch = lk_nomatch_q;

endmodule
